// File: rtl/k_fifo_pkg.sv
// Shared types and constants for the small k_fifo family.
// Pointers carry one wrap bit above the array address bits.
package k_fifo_pkg;
   localparam int PTR_W = 2;
   localparam int CNT_W = 2;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/k_fifo_2deep_mem.sv
// Two-entry register array: registered write, combinational read, no reset.
module k_fifo_2deep_mem #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [2];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/k_fifo_2deep.sv
// Two-entry valid/ready FIFO; ready and flags come straight from pointer flops.
// in_ready ignores out_ready, so no combinational path crosses the FIFO.
module k_fifo_2deep
   import k_fifo_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);
   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   logic push;
   logic pop;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[0] == rptr_q[0]) && (wptr_q[1] != rptr_q[1]);
   assign count     = cnt_t'(wptr_q - rptr_q);
   assign in_ready  = !full;
   assign out_valid = !empty;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + ptr_t'(1);
         if (pop)  rptr_d = rptr_q + ptr_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // A flushed push is dropped, so the array is not written either.
   k_fifo_2deep_mem #(
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (push && !flush),
      .waddr (wptr_q[0]),
      .wdata (in_data),
      .raddr (rptr_q[0]),
      .rdata (out_data)
   );
endmodule

// File: tb/tb_k_fifo_2deep.sv
// Bench for k_fifo_2deep: table-driven vectors plus a queue scoreboard.
module tb_k_fifo_2deep;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] count;
   logic       full;
   logic       empty;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic [1:0] ecount;
      logic       eir;
      logic       eov;
      logic [7:0] eod;
   } vec_t;
   vec_t vecs[9];

   k_fifo_2deep #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check flags against the scoreboard, then advance.
   task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      logic push_ok;
      logic pop_ok;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk("count",     32'(count),     32'(sb.size()));
      chk("in_ready",  32'(in_ready),  32'(sb.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      push_ok = iv && (sb.size() < 2);
      pop_ok  = ordy && (sb.size() != 0);
      if (fl) begin
         sb.delete();
      end else begin
         if (pop_ok) begin
            chk("out_data", 32'(out_data), 32'(sb[0]));
            $display("pop  data=%02h count=%0d", out_data, count);
            void'(sb.pop_front());
         end
         if (push_ok) begin
            sb.push_back(d);
            $display("push data=%02h count=%0d", d, count);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA1};
      vecs[1] = '{1'b1, 8'hB2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hA1};
      vecs[2] = '{1'b1, 8'hC3, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hA1};
      vecs[3] = '{1'b1, 8'hC3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hB2};
      vecs[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hC3};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00};
      vecs[6] = '{1'b1, 8'h44, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h44};
      vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_empty",     32'(empty),     32'd1);
      chk("rst_full",      32'(full),      32'd0);
      @(negedge clk);

      // Fill/drain, held third push, full-with-ready, flush priority.
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
         chk($sformatf("v%0d_count", i),     32'(count),     32'(vecs[i].ecount));
         chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].eir));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
         chk($sformatf("v%0d_full", i),      32'(full),      32'(vecs[i].ecount == 2'd2));
         chk($sformatf("v%0d_empty", i),     32'(empty),     32'(vecs[i].ecount == 2'd0));
         if (vecs[i].eov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].eod));
      end

      // Streaming: one in, one out per cycle at count 1.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b0);
         chk("stream_count", 32'(count), 32'd1);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stream_drained", 32'(empty), 32'd1);

      // Asynchronous reset between edges with two entries queued.
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(full), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count",     32'(count),     32'd0);
      chk("arst_empty",     32'(empty),     32'd1);
      chk("arst_full",      32'(full),      32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_data",  32'(out_data),  32'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("final_empty", 32'(empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
